// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// FetchUnit: instruction fetch stage with PC register and IF/ID pipeline latch.
//
// The PC is held as a 30-bit word index so that word alignment is structural:
// Address is always {pc_word, 2'b00} and can never carry stray low bits.
// Each rising edge chooses one PC action and one IF/ID action with priority
// Reset > Redirect > Stall > normal advance; Flush only affects IF/ID.
//
// Optional feature macro: FETCH_PERF_CNT_EN
//   When defined, adds FetchCount / BubbleCount outputs that count edges
//   loading a real instruction and edges loading a bubble (reset excluded).
// ----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] NOP_WORD = 32'h00000000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Instruction,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        Redirect,
    input  logic [31:0] RedirectTarget,
    output logic [31:0] Address,
    output logic [31:0] IF_ID_Instruction,
    output logic [31:0] IF_ID_PCPlus4,
    output logic        IF_ID_Valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] BubbleCount
`endif
);

    // What the PC register does on the coming edge.
    typedef enum logic [1:0] {
        PC_HOLD     = 2'd0,
        PC_ADVANCE  = 2'd1,
        PC_REDIRECT = 2'd2
    } pc_action_t;

    // What the IF/ID latch does on the coming edge.
    typedef enum logic [1:0] {
        IFID_HOLD   = 2'd0,
        IFID_LOAD   = 2'd1,
        IFID_BUBBLE = 2'd2
    } ifid_action_t;

    localparam logic [29:0] RESET_WORD = RESET_PC[31:2];

    logic [29:0]  pc_word;
    logic [29:0]  pc_word_next_seq;
    logic [29:0]  redirect_word;
    logic [31:0]  pc_plus4;
    pc_action_t   pc_action;
    ifid_action_t ifid_action;

    logic [31:0]  ifid_instruction;
    logic [31:0]  ifid_pc_plus4;
    logic         ifid_valid;

    // Low two bits of the redirect target are dropped on purpose; the PC
    // is word-addressed.
    logic         unused_target_bits;
    assign unused_target_bits = ^RedirectTarget[1:0];

    // A 30-bit word-index increment wraps exactly like a 32-bit +4, so
    // 32'hFFFFFFFC rolls over to 32'h00000000 for free.
    assign pc_word_next_seq = pc_word + 30'd1;
    assign pc_plus4         = {pc_word_next_seq, 2'b00};
    assign redirect_word    = RedirectTarget[31:2];

    // Address comes straight from the PC register, no input reaches it
    // combinationally.
    assign Address = {pc_word, 2'b00};

    assign IF_ID_Instruction = ifid_instruction;
    assign IF_ID_PCPlus4     = ifid_pc_plus4;
    assign IF_ID_Valid       = ifid_valid;

    // Decode the control inputs into per-edge actions. Reset is handled
    // in the sequential block and overrides everything decoded here.
    always_comb begin
        pc_action   = PC_ADVANCE;
        ifid_action = IFID_LOAD;
        if (Redirect) begin
            pc_action   = PC_REDIRECT;
            ifid_action = IFID_BUBBLE;
        end else if (Stall) begin
            pc_action   = PC_HOLD;
            ifid_action = Flush ? IFID_BUBBLE : IFID_HOLD;
        end else begin
            pc_action   = PC_ADVANCE;
            ifid_action = Flush ? IFID_BUBBLE : IFID_LOAD;
        end
    end

    // PC register: reset to RESET_PC, then redirect, hold or advance.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_word <= RESET_WORD;
        end else begin
            case (pc_action)
                PC_REDIRECT: pc_word <= redirect_word;
                PC_ADVANCE:  pc_word <= pc_word_next_seq;
                default:     pc_word <= pc_word;
            endcase
        end
    end

    // IF/ID latch: captures the fetched word with its PC+4, a bubble,
    // or keeps its contents while stalled.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ifid_instruction <= NOP_WORD;
            ifid_pc_plus4    <= 32'h0;
            ifid_valid       <= 1'b0;
        end else begin
            case (ifid_action)
                IFID_LOAD: begin
                    ifid_instruction <= Instruction;
                    ifid_pc_plus4    <= pc_plus4;
                    ifid_valid       <= 1'b1;
                end
                IFID_BUBBLE: begin
                    ifid_instruction <= NOP_WORD;
                    ifid_pc_plus4    <= 32'h0;
                    ifid_valid       <= 1'b0;
                end
                default: begin
                    ifid_instruction <= ifid_instruction;
                    ifid_pc_plus4    <= ifid_pc_plus4;
                    ifid_valid       <= ifid_valid;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] bubble_count;

    assign FetchCount  = fetch_count;
    assign BubbleCount = bubble_count;

    // Count real loads and bubble loads into IF/ID; a held latch counts
    // as neither, and both counters wrap naturally at 2^32.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fetch_count  <= 32'h0;
            bubble_count <= 32'h0;
        end else begin
            if (ifid_action == IFID_LOAD) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (ifid_action == IFID_BUBBLE) begin
                bubble_count <= bubble_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit: table-driven self-checking bench for fetch_unit with a
// scoreboard queue. Instruction memory model: word i holds i*3.
// Counter checks are compiled in when FETCH_PERF_CNT_EN is defined.
// ----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        reset;
    logic [31:0] instruction;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] address;
    logic [31:0] ifid_instruction;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] bubble_count;
`endif

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        logic        reset;
        logic        stall;
        logic        flush;
        logic        redirect;
        logic [31:0] target;
        logic [31:0] expAddr;
        logic [31:0] expInstr;
        logic [31:0] expPcPlus4;
        logic        expValid;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pcPlus4;
        logic        valid;
    } exp_t;

    vec_t vecs[$];
    exp_t scoreboard[$];

    fetch_unit #(
        .RESET_PC(32'h00000000),
        .NOP_WORD(NOP)
    ) dut (
        .Clk              (clk),
        .Reset            (reset),
        .Instruction      (instruction),
        .Stall            (stall),
        .Flush            (flush),
        .Redirect         (redirect),
        .RedirectTarget   (redirect_target),
        .Address          (address),
        .IF_ID_Instruction(ifid_instruction),
        .IF_ID_PCPlus4    (ifid_pc_plus4),
        .IF_ID_Valid      (ifid_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .FetchCount       (fetch_count),
        .BubbleCount      (bubble_count)
`endif
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Combinational instruction memory: word index i returns i*3.
    always_comb begin
        instruction = (address >> 2) * 32'd3;
    end

    // Guard against a hung simulation.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkVec(input logic r, input logic s, input logic f,
                                   input logic rd, input logic [31:0] t,
                                   input logic [31:0] a, input logic [31:0] i,
                                   input logic [31:0] p, input logic v);
        vec_t x;
        x.reset = r; x.stall = s; x.flush = f; x.redirect = rd; x.target = t;
        x.expAddr = a; x.expInstr = i; x.expPcPlus4 = p; x.expValid = v;
        return x;
    endfunction

    task automatic checkValue(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %08h, expected %08h", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        if (scoreboard.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL %s: scoreboard empty", tag);
            return;
        end
        e = scoreboard.pop_front();
        checkValue({tag, " addr"},    address,          e.addr);
        checkValue({tag, " instr"},   ifid_instruction, e.instr);
        checkValue({tag, " pcplus4"}, ifid_pc_plus4,    e.pcPlus4);
        checkValue({tag, " valid"},   {31'h0, ifid_valid}, {31'h0, e.valid});
    endtask

    // Drive one cycle of inputs on the falling edge, record the expected
    // result, then compare just after the following rising edge.
    task automatic applyStimulus(input vec_t v, input string tag);
        exp_t e;
        @(negedge clk);
        reset           = v.reset;
        stall           = v.stall;
        flush           = v.flush;
        redirect        = v.redirect;
        redirect_target = v.target;
        e.addr    = v.expAddr;
        e.instr   = v.expInstr;
        e.pcPlus4 = v.expPcPlus4;
        e.valid   = v.expValid;
        scoreboard.push_back(e);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        reset           = 1'b0;
        stall           = 1'b0;
        flush           = 1'b0;
        redirect        = 1'b0;
        redirect_target = 32'h0;

        //                rst  stl  fls  rdr  target        addr          instr         pc+4          v
        vecs.push_back(mkVec(1, 0, 0, 0, 32'h0,        32'h0,        NOP,          32'h0,        0));
        vecs.push_back(mkVec(0, 0, 0, 0, 32'h0,        32'h4,        32'h0,        32'h4,        1));
        vecs.push_back(mkVec(0, 0, 0, 0, 32'h0,        32'h8,        32'h3,        32'h8,        1));
        vecs.push_back(mkVec(0, 1, 0, 0, 32'h0,        32'h8,        32'h3,        32'h8,        1));
        vecs.push_back(mkVec(0, 1, 0, 0, 32'h0,        32'h8,        32'h3,        32'h8,        1));
        vecs.push_back(mkVec(0, 0, 0, 0, 32'h0,        32'hC,        32'h6,        32'hC,        1));
        vecs.push_back(mkVec(0, 0, 0, 0, 32'h0,        32'h10,       32'h9,        32'h10,       1));
        vecs.push_back(mkVec(0, 0, 1, 0, 32'h0,        32'h14,       NOP,          32'h0,        0));
        vecs.push_back(mkVec(0, 1, 1, 0, 32'h0,        32'h14,       NOP,          32'h0,        0));
        vecs.push_back(mkVec(0, 0, 0, 0, 32'h0,        32'h18,       32'hF,        32'h18,       1));
        vecs.push_back(mkVec(0, 1, 0, 1, 32'h43,       32'h40,       NOP,          32'h0,        0));
        vecs.push_back(mkVec(0, 0, 0, 0, 32'h0,        32'h44,       32'h30,       32'h44,       1));
        vecs.push_back(mkVec(0, 0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFC, NOP,          32'h0,        0));
        vecs.push_back(mkVec(0, 0, 0, 0, 32'h0,        32'h0,        32'hBFFFFFFD, 32'h0,        1));
        vecs.push_back(mkVec(0, 0, 0, 1, 32'h100,      32'h100,      NOP,          32'h0,        0));
        vecs.push_back(mkVec(0, 0, 1, 1, 32'h202,      32'h200,      NOP,          32'h0,        0));
        vecs.push_back(mkVec(0, 0, 0, 0, 32'h0,        32'h204,      32'h180,      32'h204,      1));
        vecs.push_back(mkVec(0, 1, 0, 0, 32'h0,        32'h204,      32'h180,      32'h204,      1));
        vecs.push_back(mkVec(1, 1, 1, 1, 32'h500,      32'h0,        NOP,          32'h0,        0));
        vecs.push_back(mkVec(0, 0, 0, 0, 32'h0,        32'h4,        32'h0,        32'h4,        1));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset arriving in the middle of a stall discards the held state.
        applyStimulus(mkVec(0, 0, 0, 0, 32'h0, 32'h8, 32'h3, 32'h8, 1), "midstall_run");
        applyStimulus(mkVec(0, 1, 0, 0, 32'h0, 32'h8, 32'h3, 32'h8, 1), "midstall_hold");
        applyStimulus(mkVec(1, 1, 0, 0, 32'h0, 32'h0, NOP,   32'h0, 0), "midstall_reset");
        applyStimulus(mkVec(0, 0, 0, 0, 32'h0, 32'h4, 32'h0, 32'h4, 1), "midstall_refetch");

        // Reset together with a redirect: reset wins and counters clear.
        applyStimulus(mkVec(0, 0, 0, 0, 32'h0,  32'h8, 32'h3, 32'h8, 1), "rstredir_run");
        applyStimulus(mkVec(1, 0, 0, 1, 32'h80, 32'h0, NOP,   32'h0, 0), "rstredir_reset");
`ifdef FETCH_PERF_CNT_EN
        checkValue("cnt_reset fetch",  fetch_count,  32'd0);
        checkValue("cnt_reset bubble", bubble_count, 32'd0);
`endif
        applyStimulus(mkVec(0, 0, 0, 0, 32'h0, 32'h4, 32'h0, 32'h4, 1), "cnt_free");
`ifdef FETCH_PERF_CNT_EN
        checkValue("cnt_free fetch",  fetch_count,  32'd1);
        checkValue("cnt_free bubble", bubble_count, 32'd0);
`endif
        applyStimulus(mkVec(0, 0, 1, 0, 32'h0, 32'h8, NOP, 32'h0, 0), "cnt_flush");
`ifdef FETCH_PERF_CNT_EN
        checkValue("cnt_flush fetch",  fetch_count,  32'd1);
        checkValue("cnt_flush bubble", bubble_count, 32'd1);
`endif
        applyStimulus(mkVec(0, 0, 0, 1, 32'h30, 32'h30, NOP, 32'h0, 0), "cnt_redirect");
`ifdef FETCH_PERF_CNT_EN
        checkValue("cnt_redirect fetch",  fetch_count,  32'd1);
        checkValue("cnt_redirect bubble", bubble_count, 32'd2);
`endif
        applyStimulus(mkVec(0, 1, 0, 0, 32'h0, 32'h30, NOP, 32'h0, 0), "cnt_stall");
`ifdef FETCH_PERF_CNT_EN
        checkValue("cnt_stall fetch",  fetch_count,  32'd1);
        checkValue("cnt_stall bubble", bubble_count, 32'd2);
`endif

        if (scoreboard.size() != 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", scoreboard.size());
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000: PC value loaded on reset.
REQ-002 Parameter NOP_WORD, default 32'h00000000: instruction word inserted as a bubble.
REQ-003 Clk  input  1: single clock; all state updates on rising edge.
REQ-004 Reset  input  1: synchronous, active-high reset.
REQ-005 Instruction  input  32: word returned combinationally by instruction memory for Address.
REQ-006 Stall  input  1: hold PC and IF/ID contents.
REQ-007 Flush  input  1: replace IF/ID contents with bubble.
REQ-008 Redirect  input  1: taken branch/jump; load PC from RedirectTarget.
REQ-009 RedirectTarget  input  32: byte address of next fetch.
REQ-010 Address  output  32: current PC, driven to instruction memory.
REQ-011 IF_ID_Instruction  output  32: registered fetched instruction.
REQ-012 IF_ID_PCPlus4  output  32: registered PC+4 of that instruction.
REQ-013 IF_ID_Valid  output  1: 1 = IF/ID holds a real instruction, 0 = bubble.

Function
REQ-014 Address SHALL equal the PC register directly, no combinational path from any input.
REQ-015 PC SHALL always be word-aligned; bits [1:0] of RedirectTarget are ignored and PC[1:0] forced to 2'b00.
REQ-016 Per-edge priority SHALL be Reset > Redirect > Stall > normal advance.
REQ-017 Normal (no Reset/Redirect/Stall): PC <= PC+4; IF/ID <= {Instruction, PC+4, Valid=1}, unless Flush.
REQ-018 PC+4 SHALL be 32-bit modulo; PC 32'hFFFFFFFC advances to 32'h00000000.
REQ-019 Stall without Redirect: PC and IF/ID SHALL hold unchanged, unless Flush.
REQ-020 Redirect: PC <= {RedirectTarget[31:2],2'b00}; IF/ID <= bubble, regardless of Stall or Flush.
REQ-021 Flush without Redirect: IF/ID <= bubble; PC advances by 4 if Stall=0, holds if Stall=1.
REQ-022 Bubble SHALL be IF_ID_Instruction=NOP_WORD, IF_ID_PCPlus4=32'h0, IF_ID_Valid=0.
REQ-023 Fetch-to-IF/ID latency SHALL be exactly one clock: word at Address in cycle N visible on IF/ID outputs in cycle N+1.
REQ-024 Consecutive Redirects on consecutive cycles SHALL each take effect; the last one determines PC.

Reset
REQ-025 On Reset=1 at a rising edge: PC <= RESET_PC, IF/ID <= bubble, counters <= 0.
REQ-026 Reset SHALL override Redirect, Stall and Flush asserted in the same cycle.
REQ-027 Reset mid-stall or mid-redirect SHALL discard all pending state; the first post-reset fetch is from RESET_PC.
REQ-028 Outputs SHALL be undefined only before the first reset edge; no asynchronous behaviour.

Configuration
REQ-029 Macro FETCH_PERF_CNT_EN SHALL gate a performance-counter feature.
REQ-030 With FETCH_PERF_CNT_EN defined: extra outputs FetchCount[31:0] (increments on each edge that loads IF/ID with Valid=1) and BubbleCount[31:0] (increments on each edge that loads a bubble, Reset excluded); both wrap modulo 2^32 and are cleared by Reset.
REQ-031 Without FETCH_PERF_CNT_EN: those ports and registers SHALL not exist; all other behaviour identical.

Verification
REQ-032 Reset with RESET_PC=0, then 3 free cycles, memory[i]=i*3 -> Address 0,4,8,12; IF_ID_Instruction 0,3,6 with PCPlus4 4,8,12, Valid=1.
REQ-033 Stall=1 for 2 cycles at PC=8 -> Address stays 8, IF/ID holds {3,8,1}; after release Address=12, IF/ID={6,12,1}.
REQ-034 Redirect=1, RedirectTarget=32'h00000043 with Stall=1 -> next Address=32'h40, IF_ID_Valid=0, IF_ID_Instruction=NOP_WORD.
REQ-035 Flush=1 alone at PC=16 -> Address=20, IF/ID bubble; Flush=1 with Stall=1 -> Address holds, IF/ID bubble.
REQ-036 PC forced to 32'hFFFFFFFC via Redirect, one free cycle -> Address=0, IF_ID_PCPlus4=0, Valid=1.
REQ-037 Reset and Redirect asserted together mid-run -> Address=RESET_PC, bubble; with FETCH_PERF_CNT_EN, both counters read 0.
